// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants and phase encoding for the sync generator and colour stage.
package vga_sync_gen_pkg;

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned FRAME_W = 8;

   localparam int unsigned DEF_H_DISPLAY = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_DISPLAY = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;
   localparam logic        DEF_SYNC_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      PH_ACT = 2'd0,
      PH_FP  = 2'd1,
      PH_SY  = 2'd2,
      PH_BP  = 2'd3
   } phase_e;

   function automatic int unsigned axis_total(int unsigned d, int unsigned f,
                                              int unsigned s, int unsigned b);
      return d + f + s + b;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bus: pixel enable in, coordinates, sync pins and strobes out.
interface vga_sync_gen_if;
   import vga_sync_gen_pkg::*;

   logic               i_pix_en;
   logic [CNT_W-1:0]   h_count;
   logic [CNT_W-1:0]   v_count;
   logic               VGA_HS;
   logic               VGA_VS;
   logic               o_active;
   logic               o_line_start;
   logic               o_frame_start;
   logic [FRAME_W-1:0] o_frame_cnt;

   modport master (
      input  i_pix_en,
      output h_count, v_count, VGA_HS, VGA_VS,
             o_active, o_line_start, o_frame_start, o_frame_cnt
   );

   modport slave (
      output i_pix_en,
      input  h_count, v_count, VGA_HS, VGA_VS,
             o_active, o_line_start, o_frame_start, o_frame_cnt
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SY/BP phase FSM locked to the counter ranges.
module vga_axis_counter
   import vga_sync_gen_pkg::*;
#(
   parameter int unsigned D = DEF_H_DISPLAY,
   parameter int unsigned F = DEF_H_FRONT,
   parameter int unsigned S = DEF_H_SYNC,
   parameter int unsigned B = DEF_H_BACK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   output logic [CNT_W-1:0] count,
   output phase_e           phase_nxt_c,
   output logic             wrap_c,
   output logic             in_sync
);

   localparam int unsigned TOTAL = axis_total(D, F, S, B);
   localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(D - 1);
   localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(D + F - 1);
   localparam logic [CNT_W-1:0] LAST_SY  = CNT_W'(D + F + S - 1);
   localparam logic [CNT_W-1:0] LAST_BP  = CNT_W'(TOTAL - 1);

   if (TOTAL > (1 << CNT_W) || D == 0 || F == 0 || S == 0 || B == 0) begin : g_bad_params
      $error("vga_axis_counter: illegal timing parameters");
   end

   phase_e phase;

   assign wrap_c = (count == LAST_BP);

   // Phase steps only when the counter leaves the last position of the current phase.
   always_comb begin
      phase_nxt_c = phase;
      if (adv) begin
         case (phase)
            PH_ACT:  if (count == LAST_ACT) phase_nxt_c = PH_FP;
            PH_FP:   if (count == LAST_FP)  phase_nxt_c = PH_SY;
            PH_SY:   if (count == LAST_SY)  phase_nxt_c = PH_BP;
            PH_BP:   if (count == LAST_BP)  phase_nxt_c = PH_ACT;
            default: phase_nxt_c = phase;
         endcase
      end
   end

   // Reset parks on the last position so the first advance lands on 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= LAST_BP;
         phase   <= PH_BP;
         in_sync <= 1'b0;
      end else begin
         phase   <= phase_nxt_c;
         in_sync <= (phase_nxt_c == PH_SY);
         if (adv) begin
            count <= wrap_c ? '0 : count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: coordinates, sync pins, active/line/frame strobes and frame tick.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int unsigned H_DISPLAY   = DEF_H_DISPLAY,
   parameter int unsigned H_FRONT     = DEF_H_FRONT,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BACK      = DEF_H_BACK,
   parameter int unsigned V_DISPLAY   = DEF_V_DISPLAY,
   parameter int unsigned V_FRONT     = DEF_V_FRONT,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BACK      = DEF_V_BACK,
   parameter logic        SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
   input  logic          CLK,
   input  logic          RST_N,
   vga_sync_gen_if.master bus
);

   phase_e h_phase_nxt_c;
   phase_e v_phase_nxt_c;
   logic   h_wrap_c;
   logic   v_wrap_c;
   logic   h_in_sync;
   logic   v_in_sync;
   logic   v_adv_c;

   assign v_adv_c = bus.i_pix_en && h_wrap_c;

   vga_axis_counter #(.D(H_DISPLAY), .F(H_FRONT), .S(H_SYNC), .B(H_BACK)) u_h_axis (
      .clk         (CLK),
      .rst_n       (RST_N),
      .adv         (bus.i_pix_en),
      .count       (bus.h_count),
      .phase_nxt_c (h_phase_nxt_c),
      .wrap_c      (h_wrap_c),
      .in_sync     (h_in_sync)
   );

   vga_axis_counter #(.D(V_DISPLAY), .F(V_FRONT), .S(V_SYNC), .B(V_BACK)) u_v_axis (
      .clk         (CLK),
      .rst_n       (RST_N),
      .adv         (v_adv_c),
      .count       (bus.v_count),
      .phase_nxt_c (v_phase_nxt_c),
      .wrap_c      (v_wrap_c),
      .in_sync     (v_in_sync)
   );

   // Polarity select on a registered flag; constant parameter, so no glitch path.
   assign bus.VGA_HS = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign bus.VGA_VS = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;

   // Strobes and active flag are built from next-state so they align with the new counters.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.o_active      <= 1'b0;
         bus.o_line_start  <= 1'b0;
         bus.o_frame_start <= 1'b0;
         bus.o_frame_cnt   <= '0;
      end else begin
         bus.o_active      <= (h_phase_nxt_c == PH_ACT) && (v_phase_nxt_c == PH_ACT);
         bus.o_line_start  <= v_adv_c;
         bus.o_frame_start <= v_adv_c && v_wrap_c;
         if (v_adv_c && v_wrap_c) begin
            bus.o_frame_cnt <= bus.o_frame_cnt + FRAME_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized scoreboard bench for vga_sync_gen using a reduced raster so long runs stay short.
module tb_vga_sync_gen;

   localparam int HD = 8, HF = 2, HSW = 3, HB = 2;
   localparam int VD = 5, VF = 1, VSW = 2, VB = 2;
   localparam int HT = HD + HF + HSW + HB;
   localparam int VT = VD + VF + VSW + VB;
   localparam logic SA = 1'b0;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       act;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b1;

   vga_sync_gen_if bus();

   vga_sync_gen #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
      .SYNC_ACTIVE(SA)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   exp_t q[$];
   bit mon_on = 1'b0;

   int mh, mv, mfc;

   // Expected outputs follow directly from the raster position.
   function automatic exp_t mk(int h, int v, bit ls, bit fs, int fc);
      exp_t e;
      e.h   = 10'(h);
      e.v   = 10'(v);
      e.hs  = (h >= HD + HF && h < HD + HF + HSW) ? SA : ~SA;
      e.vs  = (v >= VD + VF && v < VD + VF + VSW) ? SA : ~SA;
      e.act = (h < HD) && (v < VD);
      e.ls  = ls;
      e.fs  = fs;
      e.fc  = 8'(fc);
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t a;
      a.h   = bus.h_count;
      a.v   = bus.v_count;
      a.hs  = bus.VGA_HS;
      a.vs  = bus.VGA_VS;
      a.act = bus.o_active;
      a.ls  = bus.o_line_start;
      a.fs  = bus.o_frame_start;
      a.fc  = bus.o_frame_cnt;
      return a;
   endfunction

   task automatic compare(string name, exp_t a, exp_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d need h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d",
                  name, a.h, a.v, a.hs, a.vs, a.act, a.ls, a.fs, a.fc,
                  e.h, e.v, e.hs, e.vs, e.act, e.ls, e.fs, e.fc);
      end
   endtask

   task automatic model_reset();
      mh = HT - 1;
      mv = VT - 1;
      mfc = 0;
   endtask

   task automatic drive_now(bit pix);
      bit ls, fs;
      bus.i_pix_en = pix;
      ls = 1'b0;
      fs = 1'b0;
      if (pix) begin
         mh = (mh + 1) % HT;
         if (mh == 0) begin
            mv = (mv + 1) % VT;
            ls = 1'b1;
            fs = (mv == 0);
            if (fs) mfc = (mfc + 1) % 256;
         end
      end
      q.push_back(mk(mh, mv, ls, fs, mfc));
   endtask

   task automatic drive(bit pix);
      @(negedge CLK);
      drive_now(pix);
   endtask

   task automatic release_reset(bit pix);
      @(negedge CLK);
      RST_N = 1'b1;
      model_reset();
      drive_now(pix);
      mon_on = 1'b1;
   endtask

   // Monitor: pops one expectation per clock while running and tracks lines per frame.
   int  ls_cnt = 0;
   bit  seen_fs = 1'b0;
   always @(posedge CLK) begin
      #1;
      if (!mon_on) begin
         seen_fs = 1'b0;
      end else if (q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow got empty queue need one expectation at t=%0t", $time);
      end else begin
         exp_t e, a;
         e = q.pop_front();
         a = sample();
         compare("sb_pixel", a, e);
         if (a.fs) begin
            if (seen_fs) begin
               checks++;
               if (ls_cnt != VT) begin
                  failures++;
                  $display("FAIL lines_per_frame got %0d need %0d", ls_cnt, VT);
               end
            end
            seen_fs = 1'b1;
            ls_cnt = 1;
         end else if (a.ls) begin
            ls_cnt++;
         end
      end
   end

   initial begin
      exp_t rst_e;
      bus.i_pix_en = 1'b0;
      model_reset();
      rst_e = mk(HT - 1, VT - 1, 1'b0, 1'b0, 0);

      #1 RST_N = 1'b0;
      #1 compare("reset_async", sample(), rst_e);
      bus.i_pix_en = 1'b1;
      repeat (3) @(negedge CLK);
      compare("reset_hold", sample(), rst_e);

      release_reset(1'b1);
      repeat (2 * HT * VT) drive(1'b1);

      // Alternating enable for one full frame.
      for (int i = 0; i < 2 * HT * VT; i++) drive(i[0] == 1'b0);

      repeat (3 * HT * VT) drive(1'($urandom_range(0, 1)));

      // Long run to exercise the frame counter wrap.
      repeat (256 * HT * VT + HT) drive(1'b1);

      // Mid-frame reset at a random point inside the clock period.
      while (!(mh == HD - 2 && mv == VD - 1)) drive(1'b1);
      @(posedge CLK);
      #($urandom_range(2, 4));
      RST_N = 1'b0;
      mon_on = 1'b0;
      #1 compare("reset_midframe", sample(), rst_e);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got %0d entries need 0", q.size());
      end
      repeat (2) @(negedge CLK);
      compare("reset_midframe_hold", sample(), rst_e);

      release_reset(1'b1);
      repeat (HT * VT + 5) drive(1'($urandom_range(0, 3) != 0));

      @(posedge CLK);
      #3;
      mon_on = 1'b0;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got %0d entries need 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
